// File: rtl/pdp8_ram_arb.sv
// PDP-8 shared SRAM arbiter: a CPU and a DMA requester share one 32Kx12 SRAM port.
// Each access runs IDLE -> SETUP -> STROBE (WAIT_CYCLES cycles) -> HOLD.
// Ties in IDLE alternate, with DMA winning the first tie after reset.
module pdp8_ram_arb #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [14:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic [11:0] cpu_rdata,
  output logic        cpu_done,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [14:0] dma_addr,
  input  logic [11:0] dma_wdata,
  output logic [11:0] dma_rdata,
  output logic        dma_done,
  output logic [14:0] ram_addr,
  output logic [11:0] ram_wdata,
  input  logic [11:0] ram_rdata,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  // The counter counts down to zero, so the last STROBE cycle is the one with cnt_q == 0.
  localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_dma_q, last_dma_d;
  logic        gnt_dma_q, gnt_dma_d;
  logic        wr_q, wr_d;
  logic [14:0] addr_q, addr_d;
  logic [11:0] wdata_q, wdata_d;
  logic [11:0] cpu_rdata_q, cpu_rdata_d;
  logic [11:0] dma_rdata_q, dma_rdata_d;

  logic any_req;
  logic pick_dma;
  logic last_strobe;

  assign any_req     = cpu_req | dma_req;
  // DMA wins when alone, or on a tie when the CPU was not the one just passed over.
  assign pick_dma    = dma_req & (~cpu_req | ~last_dma_q);
  assign last_strobe = (state_q == StStrobe) && (cnt_q == 4'd0);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StSetup;
      StSetup:  state_d = StStrobe;
      StStrobe: if (cnt_q == 4'd0) state_d = StHold;
      StHold:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs decoded from the current state only.
  always_comb begin
    ram_rd   = (state_q == StStrobe) && !wr_q;
    ram_wr   = (state_q == StStrobe) && wr_q;
    cpu_done = (state_q == StHold) && !gnt_dma_q;
    dma_done = (state_q == StHold) && gnt_dma_q;
    busy     = (state_q != StIdle);
  end

  // Datapath next-state: grant latch, wait counter and read-data capture.
  always_comb begin
    cnt_d       = cnt_q;
    last_dma_d  = last_dma_q;
    gnt_dma_d   = gnt_dma_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    if ((state_q == StIdle) && any_req) begin
      gnt_dma_d  = pick_dma;
      last_dma_d = pick_dma;
      wr_d       = pick_dma ? dma_wr    : cpu_wr;
      addr_d     = pick_dma ? dma_addr  : cpu_addr;
      wdata_d    = pick_dma ? dma_wdata : cpu_wdata;
    end
    if (state_q == StSetup) begin
      cnt_d = CntLoad;
    end
    if ((state_q == StStrobe) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (last_strobe && !wr_q) begin
      if (gnt_dma_q) begin
        dma_rdata_d = ram_rdata;
      end else begin
        cpu_rdata_d = ram_rdata;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= 4'd0;
      last_dma_q  <= 1'b0;
      gnt_dma_q   <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 15'd0;
      wdata_q     <= 12'd0;
      cpu_rdata_q <= 12'd0;
      dma_rdata_q <= 12'd0;
    end else begin
      cnt_q       <= cnt_d;
      last_dma_q  <= last_dma_d;
      gnt_dma_q   <= gnt_dma_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_pdp8_ram_arb.sv
// Directed bench for pdp8_ram_arb: main instance with WAIT_CYCLES=2, plus
// WAIT_CYCLES=1 and 15 instances sharing the same inputs for strobe-width checks.
module tb_pdp8_ram_arb;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [11:0] cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_wr = 1'b0;
  logic [14:0] dma_addr = '0;
  logic [11:0] dma_wdata = '0;
  logic [11:0] rdata_drv = '0;
  logic        use_mem = 1'b0;
  logic [11:0] mem [0:32767];
  logic [11:0] ram_rdata;

  logic [11:0] cpu_rdata, dma_rdata, ram_wdata;
  logic [14:0] ram_addr;
  logic        cpu_done, dma_done, ram_rd, ram_wr, busy;

  logic [11:0] a_cpu_rdata, a_dma_rdata, a_ram_wdata;
  logic [14:0] a_ram_addr;
  logic        a_cpu_done, a_dma_done, a_ram_rd, a_ram_wr, a_busy;
  logic [11:0] b_cpu_rdata, b_dma_rdata, b_ram_wdata;
  logic [14:0] b_ram_addr;
  logic        b_cpu_done, b_dma_done, b_ram_rd, b_ram_wr, b_busy;

  always #5 clk = ~clk;

  // SRAM model driven by the main instance.
  assign ram_rdata = use_mem ? mem[ram_addr] : rdata_drv;
  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_wdata;

  pdp8_ram_arb #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .busy(busy)
  );

  pdp8_ram_arb #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_done(a_cpu_done),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(a_dma_rdata), .dma_done(a_dma_done),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(ram_rdata),
    .ram_rd(a_ram_rd), .ram_wr(a_ram_wr), .busy(a_busy)
  );

  pdp8_ram_arb #(.WAIT_CYCLES(15)) dut15 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(b_dma_rdata), .dma_done(b_dma_done),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(ram_rdata),
    .ram_rd(b_ram_rd), .ram_wr(b_ram_wr), .busy(b_busy)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Observations of one access window; cycle 0 is the IDLE cycle that samples req.
  int rd_first, rd_n, wr_first, wr_n, cdone_cyc, cdone_n, ddone_cyc, ddone_n;
  int a_rd_n, a_done, b_rd_n, b_done;
  logic overlap, unstable, busy0, busy1;
  logic [14:0] addr1;
  logic [11:0] wdata1, crdata, drdata;

  task automatic watch(input int n, input bit drop);
    rd_first = -1; rd_n = 0; wr_first = -1; wr_n = 0;
    cdone_cyc = -1; cdone_n = 0; ddone_cyc = -1; ddone_n = 0;
    a_rd_n = 0; a_done = -1; b_rd_n = 0; b_done = -1;
    overlap = 1'b0; unstable = 1'b0; busy0 = 1'bx; busy1 = 1'bx;
    crdata = 'x; drdata = 'x;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) busy0 = busy;
      if (k == 1) begin addr1 = ram_addr; wdata1 = ram_wdata; busy1 = busy; end
      if (k >= 1 && k <= W + 2 && (ram_addr !== addr1 || ram_wdata !== wdata1)) unstable = 1'b1;
      if (ram_rd) begin if (rd_first < 0) rd_first = k; rd_n++; end
      if (ram_wr) begin if (wr_first < 0) wr_first = k; wr_n++; end
      if (ram_rd && ram_wr) overlap = 1'b1;
      if (cpu_done) begin if (cdone_cyc < 0) cdone_cyc = k; cdone_n++; crdata = cpu_rdata; end
      if (dma_done) begin if (ddone_cyc < 0) ddone_cyc = k; ddone_n++; drdata = dma_rdata; end
      if (a_ram_rd) a_rd_n++;
      if (a_cpu_done && a_done < 0) a_done = k;
      if (b_ram_rd) b_rd_n++;
      if (b_cpu_done && b_done < 0) b_done = k;
      if (drop && k == 1) begin cpu_req = 1'b0; dma_req = 1'b0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [11:0] exp_mem [0:7];
  logic [11:0] dma_before;

  task automatic sb_access(input bit is_dma, input bit wr, input logic [2:0] idx,
                           input logic [11:0] d);
    logic [14:0] a;
    a = {idx, 12'o0707};
    if (is_dma) begin dma_req = 1'b1; dma_wr = wr; dma_addr = a; dma_wdata = d; end
    else begin cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; end
    watch(W + 4, 1'b1);
    check_eq("sb_done", is_dma ? ddone_cyc : cdone_cyc, W + 2);
    if (wr) exp_mem[idx] = d;
    else check_eq("sb_rdata", is_dma ? drdata : crdata, exp_mem[idx]);
  endtask

  int ev_cyc [4];
  int ev_who [4];
  int n_ev;
  logic both_done;

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_strobes", {ram_rd, ram_wr, cpu_done, dma_done}, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_ram_wdata", ram_wdata, 0);
    check_eq("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    reset = 1'b0;

    // DMA write to the top address.
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 15'o77777; dma_wdata = 12'o0001;
    watch(W + 4, 1'b1);
    check_eq("dw_busy0", busy0, 0);
    check_eq("dw_busy1", busy1, 1);
    check_eq("dw_wr_first", wr_first, 2);
    check_eq("dw_wr_n", wr_n, 2);
    check_eq("dw_rd_n", rd_n, 0);
    check_eq("dw_addr", addr1, 15'o77777);
    check_eq("dw_wdata", wdata1, 12'o0001);
    check_eq("dw_stable", unstable, 0);
    check_eq("dw_done", ddone_cyc, 4);
    check_eq("dw_done_n", ddone_n, 1);
    check_eq("dw_cpu_done_n", cdone_n, 0);

    // DMA read so dma_rdata holds a known value.
    dma_wr = 1'b0; dma_req = 1'b1; rdata_drv = 12'o1111;
    watch(W + 4, 1'b1);
    check_eq("dr_rdata", drdata, 12'o1111);
    dma_before = dma_rdata;

    // CPU read.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'o01234; rdata_drv = 12'o7654;
    watch(W + 4, 1'b1);
    check_eq("cr_addr", addr1, 15'o01234);
    check_eq("cr_rd_first", rd_first, 2);
    check_eq("cr_rd_n", rd_n, 2);
    check_eq("cr_wr_n", wr_n, 0);
    check_eq("cr_done", cdone_cyc, 4);
    check_eq("cr_done_n", cdone_n, 1);
    check_eq("cr_dma_done_n", ddone_n, 0);
    check_eq("cr_rdata", crdata, 12'o7654);
    check_eq("cr_dma_rdata_hold", dma_rdata, 12'o1111);
    check_eq("cr_overlap", overlap, 0);

    // Strobe width and latency at WAIT_CYCLES 1 and 15.
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'o00042; rdata_drv = 12'o0525;
    watch(19, 1'b1);
    check_eq("w1_rd_n", a_rd_n, 1);
    check_eq("w1_done", a_done, 3);
    check_eq("w15_rd_n", b_rd_n, 15);
    check_eq("w15_done", b_done, 17);
    check_eq("w15_rdata", b_cpu_rdata, 12'o0525);

    // Continuous tie from reset: DMA, CPU, DMA, CPU.
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b0; dma_req = 1'b1; dma_wr = 1'b0;
    n_ev = 0; both_done = 1'b0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (cpu_done && dma_done) both_done = 1'b1;
      if ((cpu_done || dma_done) && n_ev < 4) begin
        ev_cyc[n_ev] = k; ev_who[n_ev] = dma_done ? 1 : 0; n_ev++;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    check_eq("tie_n_ev", n_ev, 4);
    check_eq("tie_both", both_done, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("tie_who", ev_who[i], (i % 2 == 0) ? 1 : 0);
      check_eq("tie_cyc", ev_cyc[i], 4 + 5 * i);
    end
    repeat (8) @(posedge clk);
    #1;

    // Reset in the first STROBE cycle of a write, request held throughout.
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 15'o00100; cpu_wdata = 12'o4321;
    repeat (3) @(negedge clk);
    check_eq("ra_wr_pre", ram_wr, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("ra_wr_drop", ram_wr, 0);
    check_eq("ra_busy", busy, 0);
    check_eq("ra_done", {cpu_done, dma_done}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    watch(W + 4, 1'b1);
    check_eq("ra_wr_first", wr_first, 2);
    check_eq("ra_addr", addr1, 15'o00100);
    check_eq("ra_done_cyc", cdone_cyc, 4);

    // Scoreboard against the SRAM model.
    do_reset();
    use_mem = 1'b1;
    for (int i = 0; i < 8; i++) sb_access(i[0], 1'b1, 3'(i), 12'(i * 291 + 5));
    for (int i = 7; i >= 0; i--) sb_access(~i[0], 1'b0, 3'(i), 12'h0);
    sb_access(1'b0, 1'b1, 3'd3, 12'o7070);
    sb_access(1'b1, 1'b1, 3'd3, 12'o0707);
    sb_access(1'b0, 1'b0, 3'd3, 12'h0);
    sb_access(1'b1, 1'b0, 3'd5, 12'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pdp8_ram_arb.md
PDP8_RAM_ARB -- requirements
Module: pdp8_ram_arb

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of cycles ram_rd/ram_wr stay asserted per access (legal 1..15).
REQ-002 Clocking: one clock; reset is asynchronous and active-high. The ports are named clk and reset.
REQ-003 Ports, as name  direction  width  meaning:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  async active-high reset.
- cpu_req  in  1  CPU access request.
- cpu_wr  in  1  1=write, 0=read.
- cpu_addr  in  15  CPU word address.
- cpu_wdata  in  12  CPU write data.
- cpu_rdata  out  12  CPU read data.
- cpu_done  out  1  one-cycle completion pulse to CPU.
- dma_req, dma_wr, dma_addr[14:0], dma_wdata[11:0]  in  DMA equivalents of the cpu_* inputs.
- dma_rdata  out  12  DMA read data.
- dma_done  out  1  one-cycle completion pulse to DMA.
- ram_addr  out  15  address to the SRAM interface.
- ram_wdata  out  12  write data to the SRAM interface.
- ram_rdata  in  12  read data from the SRAM interface.
- ram_rd  out  1  read strobe, active high.
- ram_wr  out  1  write strobe, active high.
- busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-004 FSM states: IDLE, SETUP, STROBE, HOLD. IDLE->SETUP on any sampled req; SETUP->STROBE always; STROBE->HOLD after WAIT_CYCLES cycles; HOLD->IDLE always.
REQ-005 In IDLE with exactly one req high, that requester shall be granted.
REQ-006 In IDLE with both reqs high, the requester not granted last shall be granted. A last_dma flag records the last grant; after reset it is 0, so DMA wins the first tie.
REQ-007 On grant, the winner's wr, addr and wdata shall be latched. ram_addr and ram_wdata shall come from the latches and stay stable from SETUP through HOLD.
REQ-008 ram_rd shall be high only in STROBE and only for reads. ram_wr shall be high only in STROBE and only for writes. ram_rd and ram_wr shall never be high together.
REQ-009 A 4-bit counter shall be loaded in SETUP and decremented in STROBE, so STROBE lasts exactly WAIT_CYCLES cycles.
REQ-010 For reads, ram_rdata shall be captured on the clock edge that ends the last STROBE cycle, into cpu_rdata or dma_rdata per grant. The other rdata register shall hold its value.
REQ-011 The granted requester's done shall be high during HOLD only, for exactly one cycle. The other done shall stay low. rdata shall be valid while done is high.
REQ-012 Latency: with req sampled in IDLE at cycle 0, done shall be high at cycle WAIT_CYCLES+2. Throughput shall be one access per WAIT_CYCLES+3 cycles.
REQ-013 Requesters shall hold addr/wr/wdata stable from req until done. A req still high in the IDLE cycle after HOLD is a new access.
REQ-014 A req change outside IDLE shall not affect the current access. A non-granted req stays pending with no loss.
REQ-015 busy shall be high in SETUP, STROBE and HOLD.

Reset
REQ-016 Asserting reset shall immediately force: FSM=IDLE, ram_rd=0, ram_wr=0, cpu_done=0, dma_done=0, busy=0, last_dma=0, ram_addr=0, ram_wdata=0, cpu_rdata=0, dma_rdata=0, counter=0.
REQ-017 Reset mid-access shall abort without generating done. The first IDLE after release shall re-arbitrate from a clean state.

Verification
REQ-018 CPU read, WAIT_CYCLES=2, cpu_addr=15'o01234, ram_rdata=12'o7654: ram_rd high cycles 2-3, cpu_done at cycle 4, cpu_rdata=12'o7654, dma_rdata unchanged.
REQ-019 DMA write, dma_addr=15'o77777, dma_wdata=12'o0001: ram_wr high cycles 2-3, ram_addr/ram_wdata stable cycles 1-4, ram_rd never high, dma_done at cycle 4.
REQ-020 Both reqs high from reset, held continuously: grant order DMA, CPU, DMA, CPU. Each done is separated by 5 cycles. Never two dones in the same cycle.
REQ-021 Reset asserted in the first STROBE cycle of a write: ram_wr drops asynchronously, no done occurs, busy=0. After release with req held, the access restarts and completes in 4 cycles.
REQ-022 WAIT_CYCLES=1 and WAIT_CYCLES=15: strobe width is 1 and 15 cycles, done latency is 3 and 17 cycles.
REQ-023 Random bench with a scoreboard: every access to a 32Kx12 model returns the last value written to that address.
